lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller sitting directly downstream of the instruction decoder in the single-cycle RISC-V core. It consumes the decoder's one-hot memory flags (sw, sh, sb, lb, lh, lw, lbu, lhu), the ALU-computed effective address and the rs2 store data. It runs a req/ready handshake to data memory with byte-lane strobes and returns sign- or zero-extended load data. While the access is in flight it stalls the core's PC.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: REQ-state wait limit, legal range 1..255; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sw, sh, sb, lb, lh, lw, lbu, lhu  in  1 each  one-hot decoder flags, held stable by the core while stall=1
- addr  in  32  effective byte address
- store_data  in  32  rs2 value
- stall  out  1  freeze PC/register writeback
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse; load_data valid
- misalign  out  1  one-cycle pulse; access dropped
- bus_err  out  1  one-cycle timeout pulse (tied 0 without LSU_TIMEOUT_EN)
- mem_req  out  1  request valid
- mem_we  out  1  1=store
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts/completes the current request
- mem_rdata  in  32  read word, valid when mem_ready=1

## Operation
- FSM states: IDLE, REQ, DONE, FAULT. Reset state is IDLE.
- Reset values: all registered outputs are 0. This includes load_data, mem_addr, mem_be, mem_wdata and mem_we.
- Flag priority if more than one flag is set (illegal input): lw > lh > lhu > lb > lbu > sw > sh > sb.
- IDLE, any flag set:
  - Misaligned access (lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1) → FAULT.
  - Otherwise capture mem_addr, mem_be, mem_wdata, mem_we, the op type and addr[1:0], then → REQ.
- REQ: mem_req=1 and all mem_* outputs are held stable. On mem_ready=1 → DONE. For loads, the formatted mem_rdata is registered into load_data.
- DONE: load_valid=1 for loads only, stall=0 → IDLE. Flags present in this cycle are ignored; they still belong to the completed instruction.
- FAULT: misalign=1, stall=0, no memory request → IDLE.
- stall = (IDLE & any flag) | REQ.
- Store formatting:
  - sb: mem_wdata={4{store_data[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - sh: mem_wdata={2{store_data[15:0]}}, mem_be=addr[1]?4'b1100:4'b0011.
  - sw: mem_wdata=store_data, mem_be=4'b1111.
- Loads: mem_be is set as for the matching store width.
- Load formatting:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended to 32 bits.
  - lh/lhu: half at addr[1], sign- or zero-extended to 32 bits.
  - lw: full word.
- load_data holds its value until the next load completes.
- mem_ready outside REQ is ignored.
- Reset asserted mid-REQ: mem_req drops immediately (async), FSM goes to IDLE, no load_valid is produced. The memory side must tolerate the abandoned request.

## Timing
- Flags arrive in cycle T (IDLE). mem_req rises at T+1.
- With mem_ready=1 at T+1+W (W≥0 wait states): DONE occurs at T+2+W, and load_valid/load_data are valid in that cycle.
- stall is high for exactly 2+W cycles (T..T+1+W). The PC advances at the end of the DONE cycle.
- Misaligned access: stall is high in cycle T only. misalign pulses at T+1.
- load_valid, misalign and bus_err are registered-state decodes, each exactly one cycle wide.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES: FSM → FAULT-like state ERR (bus_err=1, stall=0, load_data unchanged) → IDLE.
  - mem_ready in the same cycle as the limit wins, and the access completes normally.
- LSU_TIMEOUT_EN undefined: no counter, bus_err tied 0, REQ waits indefinitely.

## Test plan
- lw, addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0xDEADBEEF → mem_be=4'b1111, stall 2 cycles, load_data=0xDEADBEEF with load_valid pulse.
- lb, addr=0x103, mem_rdata=0x80FF_0000 → mem_be=4'b1000, load_data=0xFFFFFF80. Same access as lbu → 0x00000080.
- sh, addr=0x202, store_data=0x1234ABCD, mem_ready after 3 wait states → mem_wdata=0xABCDABCD, mem_be=4'b1100, mem_we=1, stall 5 cycles, outputs stable throughout REQ.
- lw, addr=0x101 → no mem_req, misalign pulse at T+1, stall 1 cycle. sh at 0x203 → same response.
- rst pulsed during REQ of sw → mem_req falls without a clock edge, all outputs 0, next lw proceeds normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 → bus_err pulse after 4 REQ cycles, stall released, no load_valid.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Data-memory request bus between the load/store controller and memory.
// The controller is the master: it owns req/we/addr/be/wdata.
// Memory answers with ready and, for loads, the read word.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller for the single-cycle RISC-V core.
// Turns the decoder's one-hot memory flags into a req/ready access on the
// data bus, formats store lanes and byte enables, and extends load data.
// The core PC is stalled while an access is being issued or is in flight.
// Optional feature: define LSU_TIMEOUT_EN to abandon a request that stays
// unanswered for TIMEOUT_CYCLES cycles and report it on bus_err.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw,
    input  logic               sh,
    input  logic               sb,
    input  logic               lb,
    input  logic               lh,
    input  logic               lw,
    input  logic               lbu,
    input  logic               lhu,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    output logic               stall,
    output logic [31:0]        load_data,
    output logic               load_valid,
    output logic               misalign,
    output logic               bus_err,
    lsu_ctrl_if.master         mem
);

    // ERR is only ever entered when the timeout feature is built in.
    typedef enum logic [2:0] {IDLE, REQ, DONE, FAULT, ERR} state_t;
    // Enum order doubles as the priority order for illegal multi-flag input.
    typedef enum logic [2:0] {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB} op_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("lsu_ctrl: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t      state_q, state_d;
    op_t         op_q, dec_op;
    logic [1:0]  lane_q;
    logic        any_flag;
    logic        dec_misalign;
    logic        dec_we;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] fmt_load;
    logic        op_is_load;
    logic        timeout_hit;

    // Decode the flags by priority and precompute alignment, lanes and data.
    always_comb begin
        any_flag     = sw | sh | sb | lb | lh | lw | lbu | lhu;
        dec_op       = OP_LW;
        dec_misalign = 1'b0;
        dec_we       = 1'b0;
        dec_be       = 4'b1111;
        dec_wdata    = store_data;
        if (lw)       dec_op = OP_LW;
        else if (lh)  dec_op = OP_LH;
        else if (lhu) dec_op = OP_LHU;
        else if (lb)  dec_op = OP_LB;
        else if (lbu) dec_op = OP_LBU;
        else if (sw)  dec_op = OP_SW;
        else if (sh)  dec_op = OP_SH;
        else if (sb)  dec_op = OP_SB;
        case (dec_op)
            OP_LW, OP_SW: begin
                dec_misalign = (addr[1:0] != 2'b00);
                dec_be       = 4'b1111;
                dec_wdata    = store_data;
            end
            OP_LH, OP_LHU, OP_SH: begin
                dec_misalign = addr[0];
                dec_be       = addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata    = {2{store_data[15:0]}};
            end
            default: begin
                dec_be    = 4'b0001 << addr[1:0];
                dec_wdata = {4{store_data[7:0]}};
            end
        endcase
        dec_we = (dec_op == OP_SW) || (dec_op == OP_SH) || (dec_op == OP_SB);
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        logic [7:0]  rd_byte;
        logic [15:0] rd_half;
        rd_byte  = mem.mem_rdata[7:0];
        rd_half  = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (lane_q)
            2'd1:    rd_byte = mem.mem_rdata[15:8];
            2'd2:    rd_byte = mem.mem_rdata[23:16];
            2'd3:    rd_byte = mem.mem_rdata[31:24];
            default: rd_byte = mem.mem_rdata[7:0];
        endcase
        case (op_q)
            OP_LH:   fmt_load = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  fmt_load = {16'h0000, rd_half};
            OP_LB:   fmt_load = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  fmt_load = {24'h000000, rd_byte};
            default: fmt_load = mem.mem_rdata;
        endcase
        op_is_load = (op_q == OP_LW) || (op_q == OP_LH) || (op_q == OP_LHU) ||
                     (op_q == OP_LB) || (op_q == OP_LBU);
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // Count REQ cycles without an answer; cleared while idle so each access starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   wait_cnt <= 8'd0;
        else if (state_q != REQ)                   wait_cnt <= 8'd0;
        else if (!mem.mem_ready)                   wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout_hit = !mem.mem_ready && (wait_cnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; async reset abandons any in-flight request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and the state-decoded handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        mem.mem_req = 1'b0;
        load_valid  = 1'b0;
        misalign    = 1'b0;
        bus_err     = 1'b0;
        case (state_q)
            IDLE: begin
                stall = any_flag;
                if (any_flag) state_d = dec_misalign ? FAULT : REQ;
            end
            REQ: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ready)    state_d = DONE;
                else if (timeout_hit) state_d = ERR;
            end
            DONE: begin
                load_valid = op_is_load;
                state_d    = IDLE;
            end
            FAULT: begin
                misalign = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                bus_err = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the access on issue; bus outputs then stay frozen through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_addr  <= 32'h0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_we    <= 1'b0;
            op_q          <= OP_LW;
            lane_q        <= 2'b00;
        end else if (state_q == IDLE && any_flag && !dec_misalign) begin
            mem.mem_addr  <= {addr[31:2], 2'b00};
            mem.mem_be    <= dec_be;
            mem.mem_wdata <= dec_wdata;
            mem.mem_we    <= dec_we;
            op_q          <= dec_op;
            lane_q        <= addr[1:0];
        end
    end

    // Register the formatted read word when a load completes; held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            load_data <= 32'h0;
        else if (state_q == REQ && mem.mem_ready && op_is_load) load_data <= fmt_load;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a table of accesses run through a small
// memory responder, expected load results queued at issue and checked at
// completion, plus hand sequences for misalignment, reset and timeouts.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw = 0, sh = 0, sb = 0, lb = 0, lh = 0, lw = 0, lbu = 0, lhu = 0;
    logic [31:0] addr = '0, store_data = '0;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] load_data;

    lsu_ctrl_if mif();

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .sw(sw), .sh(sh), .sb(sb), .lb(lb), .lh(lh), .lw(lw), .lbu(lbu), .lhu(lhu),
        .addr(addr), .store_data(store_data),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misalign(misalign), .bus_err(bus_err),
        .mem(mif.master)
    );

    always #5 clk = ~clk;

    // Flag bit order: lw lh lhu lb lbu sw sh sb
    localparam logic [7:0] F_LW = 8'h80, F_LH = 8'h40, F_LHU = 8'h20, F_LB = 8'h10,
                           F_LBU = 8'h08, F_SW = 8'h04, F_SH = 8'h02, F_SB = 8'h01;

    typedef struct {
        logic [7:0]  flags;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } vec_t;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_load = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveFlags(input logic [7:0] f);
        {lw, lh, lhu, lb, lbu, sw, sh, sb} = f;
    endtask

    // Run one aligned access; the memory answers after v.waits wait states.
    task automatic applyStimulus(input vec_t v);
        int          stall_cnt;
        logic        is_load;
        logic [31:0] exp;
        is_load   = (v.flags[7:3] != 5'b0);
        stall_cnt = 0;
        driveFlags(v.flags);
        addr       = v.addr;
        store_data = v.sdata;
        mif.mem_ready = 1'b0;
        if (is_load) sb_q.push_back(v.ldata);
        #1;
        if (stall) stall_cnt++;
        checkOutput("mem_req_issue_cycle", {31'b0, mif.mem_req}, 32'd0);
        @(negedge clk);
        for (int c = 0; c <= v.waits; c++) begin
            if (stall) stall_cnt++;
            checkOutput("mem_req", {31'b0, mif.mem_req}, 32'd1);
            checkOutput("mem_addr", mif.mem_addr, {v.addr[31:2], 2'b00});
            checkOutput("mem_be", {28'b0, mif.mem_be}, {28'b0, v.be});
            checkOutput("mem_we", {31'b0, mif.mem_we}, {31'b0, v.we});
            checkOutput("bus_err_in_req", {31'b0, bus_err}, 32'd0);
            if (v.we) checkOutput("mem_wdata", mif.mem_wdata, v.wdata);
            mif.mem_ready = (c == v.waits);
            mif.mem_rdata = (c == v.waits) ? v.rdata : ~v.rdata;
            @(negedge clk);
        end
        mif.mem_ready = 1'b0;
        mif.mem_rdata = $urandom;
        if (stall) stall_cnt++;
        checkOutput("stall_cycles", 32'(stall_cnt), 32'(2 + v.waits));
        checkOutput("load_valid", {31'b0, load_valid}, {31'b0, is_load});
        checkOutput("mem_req_done", {31'b0, mif.mem_req}, 32'd0);
        if (load_valid) begin
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                checkOutput("load_data", load_data, exp);
                last_load = exp;
            end else begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL unexpected_load_valid: got 1, expected 0");
            end
        end else begin
            checkOutput("load_data_hold", load_data, last_load);
        end
        // Flags are still present for one more cycle; they must not re-issue.
        @(negedge clk);
        checkOutput("no_reissue", {31'b0, mif.mem_req}, 32'd0);
        checkOutput("load_valid_width", {31'b0, load_valid}, 32'd0);
        driveFlags(8'h00);
    endtask

    // Misaligned access: one stall cycle, misalign pulse next cycle, no request.
    task automatic runMisalign(input logic [7:0] f, input logic [31:0] a);
        driveFlags(f);
        addr = a;
        #1;
        checkOutput("mis_stall_T", {31'b0, stall}, 32'd1);
        @(negedge clk);
        checkOutput("mis_pulse", {31'b0, misalign}, 32'd1);
        checkOutput("mis_stall_T1", {31'b0, stall}, 32'd0);
        checkOutput("mis_no_req", {31'b0, mif.mem_req}, 32'd0);
        driveFlags(8'h00);
        @(negedge clk);
        checkOutput("mis_pulse_width", {31'b0, misalign}, 32'd0);
        checkOutput("mis_no_req_after", {31'b0, mif.mem_req}, 32'd0);
    endtask

    vec_t vecs[14];
    vec_t v;

    initial begin
        vecs[0]  = '{F_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{F_LB,  32'h103, 32'h0,        32'h80FF0000, 0, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{F_LBU, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b1000, 1'b0, 32'h0,        32'h00000080};
        vecs[3]  = '{F_SH,  32'h202, 32'h1234ABCD, 32'h0,        3, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{F_SB,  32'h101, 32'h000000A5, 32'h0,        1, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0};
        vecs[5]  = '{F_SW,  32'h300, 32'hCAFEF00D, 32'h0,        2, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{F_LH,  32'h102, 32'h0,        32'h80017FFF, 1, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{F_LHU, 32'h100, 32'h0,        32'h8001F00F, 0, 4'b0011, 1'b0, 32'h0,        32'h0000F00F};
        vecs[8]  = '{F_LH,  32'h100, 32'h0,        32'h1234F00F, 0, 4'b0011, 1'b0, 32'h0,        32'hFFFFF00F};
        vecs[9]  = '{F_LB,  32'h101, 32'h0,        32'h00007F00, 2, 4'b0010, 1'b0, 32'h0,        32'h0000007F};
        vecs[10] = '{F_SH,  32'h200, 32'h1234ABCD, 32'h0,        0, 4'b0011, 1'b1, 32'hABCDABCD, 32'h0};
        vecs[11] = '{F_SB,  32'h103, 32'h0000005A, 32'h0,        0, 4'b1000, 1'b1, 32'h5A5A5A5A, 32'h0};
        vecs[12] = '{F_LW | F_SB, 32'h100, 32'h0,  32'h11223344, 0, 4'b1111, 1'b0, 32'h0,        32'h11223344};
        vecs[13] = '{F_SH | F_SB, 32'h102, 32'h0000BEEF, 32'h0,  0, 4'b1100, 1'b1, 32'hBEEFBEEF, 32'h0};

        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_req", {31'b0, mif.mem_req}, 32'd0);
        checkOutput("rst_mem_addr", mif.mem_addr, 32'h0);
        checkOutput("rst_load_data", load_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_stall", {31'b0, stall}, 32'd0);
        checkOutput("idle_outputs", {28'b0, load_valid, misalign, bus_err, mif.mem_req}, 32'd0);
        checkOutput("idle_be_wdata", {mif.mem_wdata[27:0], mif.mem_be}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            $display("[TB] vector %0d: flags=%02h addr=%08h", i, vecs[i].flags, vecs[i].addr);
            applyStimulus(vecs[i]);
        end

        runMisalign(F_LW, 32'h101);
        runMisalign(F_SH, 32'h203);
        runMisalign(F_LHU, 32'h105);

        // A stray ready while idle must not complete anything.
        mif.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("stray_ready_lv", {31'b0, load_valid}, 32'd0);
        checkOutput("stray_ready_req", {31'b0, mif.mem_req}, 32'd0);
        checkOutput("stray_ready_ld", load_data, last_load);
        mif.mem_ready = 1'b0;

        // Reset in the middle of a store request drops everything without a clock edge.
        driveFlags(F_SW);
        addr = 32'h300;
        store_data = 32'h13572468;
        @(negedge clk);
        checkOutput("rst_mid_req_before", {31'b0, mif.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        driveFlags(8'h00);
        #1;
        checkOutput("rst_mid_req", {31'b0, mif.mem_req}, 32'd0);
        checkOutput("rst_mid_addr", mif.mem_addr, 32'h0);
        checkOutput("rst_mid_wdata", mif.mem_wdata, 32'h0);
        checkOutput("rst_mid_be_we", {27'b0, mif.mem_we, mif.mem_be}, 32'h0);
        checkOutput("rst_mid_ld", load_data, 32'h0);
        checkOutput("rst_mid_flags_out", {28'b0, stall, load_valid, misalign, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_load = 32'h0;
        @(negedge clk);
        checkOutput("rst_no_lv", {31'b0, load_valid}, 32'd0);
        applyStimulus(vecs[0]);

`ifdef LSU_TIMEOUT_EN
        // Unanswered load: four REQ cycles, then a bus_err pulse and release.
        driveFlags(F_LW);
        addr = 32'h400;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            checkOutput("to_req", {31'b0, mif.mem_req}, 32'd1);
            checkOutput("to_stall", {31'b0, stall}, 32'd1);
            @(negedge clk);
        end
        checkOutput("to_bus_err", {31'b0, bus_err}, 32'd1);
        checkOutput("to_stall_rel", {31'b0, stall}, 32'd0);
        checkOutput("to_no_lv", {31'b0, load_valid}, 32'd0);
        checkOutput("to_req_drop", {31'b0, mif.mem_req}, 32'd0);
        checkOutput("to_ld_hold", load_data, last_load);
        driveFlags(8'h00);
        @(negedge clk);
        checkOutput("to_bus_err_width", {31'b0, bus_err}, 32'd0);
        // Ready on the limit cycle wins over the timeout.
        v = '{F_LW, 32'h404, 32'h0, 32'h0BADF00D, 3, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D};
        applyStimulus(v);
`else
        // Without the timeout, a long wait simply keeps waiting.
        v = '{F_LHU, 32'h406, 32'h0, 32'hC0DE0000, 20, 4'b1100, 1'b0, 32'h0, 32'h0000C0DE};
        applyStimulus(v);
`endif

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
